alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Request/response front end for the 16-bit combinational ALU.
- Accepts an opcode plus operands over a valid/ready handshake and derives the ALU control bits (ci, nb, ic, na, xo, no) and operand muxing.
- Performs single-pass operations in one cycle.
- Builds shift-right (logical and arithmetic), which the ALU lacks, by iterating rotate-through-carry passes over the ALU.
- Sits between the instruction decode/control path and the ALU.

Parameters:
- WIDTH, 16, datapath width; ALU width; shift iteration count = WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op  input  4  opcode (see package)
- req_a  input  WIDTH  operand A
- req_b  input  WIDTH  operand B; ignored for INC/DEC/NOT/NEG/SHL/SHR/SAR
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  WIDTH  result
- rsp_carry  output  1  ALU carry out of final pass; for SHR/SAR, the bit shifted out
- rsp_err  output  1  illegal opcode flag, valid with rsp_valid

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset state: IDLE, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_err=0, iteration counter=0.
- req_ready = (state==IDLE). rsp_valid = (state==RESP).
- States: IDLE, EXEC, SHIFT, RESP.
  - IDLE: on req_valid&&req_ready, latch op, a, b into registers.
    - Shift ops (SHR, SAR): load acc=a and carry reg c (SHR: c=0; SAR: c=a[WIDTH-1]); clear the counter; go to SHIFT.
    - All other ops: go to EXEC.
  - EXEC: drive the ALU from the latched registers. At the next edge capture out→rsp_data and co→rsp_carry; go to RESP.
    - Illegal opcode (12–15): rsp_data=0, rsp_carry=0, rsp_err=1. rsp_err is 0 for every legal op.
  - SHIFT: drive the ALU with a=b=acc, ci=c, all other control bits 0. Each edge: acc<=out, c<=co, count++.
    - After the WIDTH-th iteration (count==WIDTH-1 at the edge): rsp_data=acc result, rsp_carry=co; go to RESP.
    - Correctness: WIDTH rotate-lefts of the (WIDTH+1)-bit ring {c,acc} equals one rotate-right. The result is {c0, a[WIDTH-1:1]} and the shifted-out bit is a[0].
  - RESP: hold rsp_* stable while rsp_valid&&!rsp_ready. On rsp_ready, return to IDLE; req_ready rises the following cycle (no same-cycle pass-through).
- Latency from the accept edge N:
  - single-pass ops and illegal opcodes: rsp_valid high after edge N+1;
  - shifts: rsp_valid high after edge N+WIDTH (N+16 at the default WIDTH).
- Control-bit map (ci nb ic na xo no). Operand B is forced to 0 for INC, DEC, NOT and NEG; B=A for SHL.
  - ADD 000000
  - SUB 110000
  - XOR 001000
  - INC 100000
  - DEC 010000
  - NOT 011000
  - NEG 100100
  - OR 001010
  - AND 011111
  - SHL 000000 with B=A
- Arithmetic wraps modulo 2^WIDTH; carry is the raw ALU co.
- Reset asserted mid-EXEC/SHIFT/RESP aborts the operation with no response; outputs return to reset values immediately.
- Request fields are sampled only at the accept edge; later changes are ignored.

Decomposition:
- Shared package alu_pkg:
  - opcode enum: ADD=0, SUB=1, XOR=2, INC=3, DEC=4, NOT=5, NEG=6, OR=7, AND=8, SHL=9, SHR=10, SAR=11;
  - state enum;
  - packed struct of the six ALU control bits;
  - constant function opcode→control struct.
- One sub-module: instantiate the existing ALU once. No other children; the counter and FSM live in alu_sequencer.

Test Plan:
- SUB a=10 b=4, rsp_ready=1 → rsp_valid exactly 1 cycle after accept, rsp_data=6, rsp_err=0. Back-to-back ADD 9+8 → 17; ADD 65534+2 → 0, rsp_carry=1.
- SHR a=0x0005 → rsp_valid 16 cycles after accept, rsp_data=0x0002, rsp_carry=1, req_ready low throughout. SAR a=0x8004 → 0xC002, carry 0. SHR a=0x8004 → 0x4002.
- INC/DEC/NOT/NEG with a=16, b=0xFFFF (must be ignored) → 17, 15, 65519, 0xFFF0.
- OR 10|9 → 11 and AND 10&9 → 8. Hold rsp_ready=0 for 5 cycles → rsp_data/rsp_carry stable, req_ready=0, result delivered on the first rsp_ready cycle.
- Opcode 13, a=1 b=1 → rsp_valid after 1 cycle, rsp_data=0, rsp_carry=0, rsp_err=1.
- Assert rst_n=0 at iteration 7 of a SAR → rsp_valid=0 and req_ready=1 after release. A subsequent ADD 1+1 → 2 with no stale result emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: opcodes, FSM states, ALU control bits
// and the opcode-to-control decode.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_XOR = 4'd2,
        OP_INC = 4'd3,
        OP_DEC = 4'd4,
        OP_NOT = 4'd5,
        OP_NEG = 4'd6,
        OP_OR  = 4'd7,
        OP_AND = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10,
        OP_SAR = 4'd11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Field order matches the written control-bit strings, MSB first.
    typedef struct packed {
        logic ci;
        logic nb;
        logic ic;
        logic na;
        logic xo;
        logic no;
    } alu_ctrl_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_SAR;
    endfunction

    function automatic alu_ctrl_t op_ctrl(input logic [3:0] op);
        alu_ctrl_t c;
        case (op)
            OP_SUB:  c = alu_ctrl_t'(6'b110000);
            OP_XOR:  c = alu_ctrl_t'(6'b001000);
            OP_INC:  c = alu_ctrl_t'(6'b100000);
            OP_DEC:  c = alu_ctrl_t'(6'b010000);
            OP_NOT:  c = alu_ctrl_t'(6'b011000);
            OP_NEG:  c = alu_ctrl_t'(6'b100100);
            OP_OR:   c = alu_ctrl_t'(6'b001010);
            OP_AND:  c = alu_ctrl_t'(6'b011111);
            default: c = alu_ctrl_t'(6'b000000);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational 16-bit ALU: optional operand inversion, add-with-carry or
// carry-inhibited XOR/OR, optional output inversion.
module alu_sequencer_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_ctrl_t        ctrl,
    output logic [WIDTH-1:0] out,
    output logic             co
);

    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;

    always_comb begin
        a_m = ctrl.na ? ~a : a;
        b_m = ctrl.nb ? ~b : b;
        sum = {1'b0, a_m} + {1'b0, b_m} + (WIDTH+1)'(ctrl.ci);
        // With carries inhibited, xo widens the per-bit XOR to an OR.
        if (ctrl.ic) begin
            res = ctrl.xo ? (a_m | b_m) : (a_m ^ b_m);
            co  = 1'b0;
        end else begin
            res = sum[WIDTH-1:0];
            co  = sum[WIDTH];
        end
        out = ctrl.no ? ~res : res;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Valid/ready front end for the ALU: single-pass ops take one cycle, SHR/SAR
// are built from WIDTH rotate-through-carry passes.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_err_q, rsp_err_d;

    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic             alu_co;
    alu_ctrl_t        alu_ctrl;

    // a_q doubles as the shift accumulator; in SHIFT the ALU computes acc+acc+c.
    always_comb begin
        alu_a = a_q;
        if (state_q == ST_SHIFT) begin
            alu_b       = a_q;
            alu_ctrl    = '0;
            alu_ctrl.ci = c_q;
        end else begin
            alu_ctrl = op_ctrl(op_q);
            case (op_q)
                OP_INC, OP_DEC, OP_NOT, OP_NEG: alu_b = '0;
                OP_SHL:                         alu_b = a_q;
                default:                        alu_b = b_q;
            endcase
        end
    end

    alu_sequencer_alu #(.WIDTH(WIDTH)) u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .ctrl (alu_ctrl),
        .out  (alu_out),
        .co   (alu_co)
    );

    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (req_op == OP_SHR || req_op == OP_SAR) begin
                        c_d     = (req_op == OP_SAR) ? req_a[WIDTH-1] : 1'b0;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                rsp_data_d  = op_is_legal(op_q) ? alu_out : '0;
                rsp_carry_d = op_is_legal(op_q) ? alu_co : 1'b0;
                rsp_err_d   = !op_is_legal(op_q);
                state_d     = ST_RESP;
            end
            ST_SHIFT: begin
                a_d   = alu_out;
                c_d   = alu_co;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    rsp_data_d  = alu_out;
                    rsp_carry_d = alu_co;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            default: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;

endmodule
